multi_cycle_ctrl: RTL

Multi-cycle sequencer for the RV32I core datapath. Steps each instruction through fetch, decode, execute, memory and writeback, using the combinational instruction decoder for classification. Drives instruction-memory and data-memory request/acknowledge handshakes and per-stage register write enables. Bounds every memory wait with a timeout.

---
 rtl/core_pkg.sv | 33 +++
 rtl/mem_wait_timer.sv | 36 +++
 rtl/multi_cycle_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types for the RV32I core datapath.
// This package holds the instruction classes, the sequencer state encoding and the trap causes.
// The decoder and the multi-cycle sequencer both import it.
package core_pkg;

  // Decoder classification of the instruction register. Codes 5-7 are illegal.
  typedef enum logic [2:0] {
    IC_ALU    = 3'd0,
    IC_LOAD   = 3'd1,
    IC_STORE  = 3'd2,
    IC_BRANCH = 3'd3,
    IC_JUMP   = 3'd4
  } inst_class_e;

  // Sequencer states. The numeric values are visible on the debug port.
  typedef enum logic [2:0] {
    CS_FETCH  = 3'd0,
    CS_DECODE = 3'd1,
    CS_EXEC   = 3'd2,
    CS_MEM    = 3'd3,
    CS_WB     = 3'd4,
    CS_TRAP   = 3'd5
  } ctrl_state_e;

  // Reason the core stopped.
  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_ILLEGAL = 2'd1,
    TC_IMEM_TO = 2'd2,
    TC_DMEM_TO = 2'd3
  } trap_cause_e;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: a saturating wait counter that bounds a memory handshake.
// clr_i has priority over en_i. expired_o is high while the count sits at its maximum.
module mem_wait_timer #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and stop at MAX instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == MAX);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: the multi-cycle instruction sequencer for the RV32I core.
// It steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
// It drives the imem/dmem request lines and the IR/PC/RF write enables.
//
// Handshake: a request (imem_req, dmem_req) stays high for every cycle the FSM
// sits in the requesting state. The matching ack completes the transfer in the
// cycle where ack is high. An ack in any other state is ignored. An ack in the
// same cycle the request first rises is legal.
//
// Optional build macro MULTI_CYCLE_CTRL_PERF_EN adds two outputs:
//   - cycle_cnt: counts every cycle the core is not in TRAP.
//   - instret_cnt: counts every pc_we pulse.
module multi_cycle_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic [2:0]  inst_class,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        halted,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  localparam logic [2:0] S_FETCH  = CS_FETCH;
  localparam logic [2:0] S_DECODE = CS_DECODE;
  localparam logic [2:0] S_EXEC   = CS_EXEC;
  localparam logic [2:0] S_MEM    = CS_MEM;
  localparam logic [2:0] S_WB     = CS_WB;
  localparam logic [2:0] S_TRAP   = CS_TRAP;

  logic [2:0] state_q, state_d;
  logic [2:0] cls_q, cls_d;
  logic [1:0] cause_q, cause_d;
  logic       wait_en, wait_clr, wait_expired;

  mem_wait_timer #(.W(TIMEOUT_W)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wait_clr),
    .en_i      (wait_en),
    .expired_o (wait_expired)
  );

  // Next-state logic. cls_q is the only class source after DECODE.
  // An ack in the limit cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cause_d = cause_q;
    wait_en = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = TC_IMEM_TO;
        end else begin
          wait_en = 1'b1;
        end
      end
      S_DECODE: begin
        cls_d = inst_class;
        if (inst_class > IC_JUMP) begin
          state_d = S_TRAP;
          cause_d = TC_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if ((cls_q == IC_LOAD) || (cls_q == IC_STORE)) state_d = S_MEM;
        else if (cls_q == IC_BRANCH)                   state_d = S_FETCH;
        else                                           state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = (cls_q == IC_STORE) ? S_FETCH : S_WB;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = TC_DMEM_TO;
        end else begin
          wait_en = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Each wait starts from zero in every new state.
  assign wait_clr = (state_d != state_q);

  // State, latched class and trap cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= IC_ALU;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
    end
  end

  // Moore outputs, plus the ack-qualified ir_we and store pc_we pulses.
  assign imem_req   = (state_q == S_FETCH);
  assign ir_we      = (state_q == S_FETCH) && imem_ack;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && (cls_q == IC_STORE);
  assign rf_we      = (state_q == S_WB);
  assign pc_we      = (state_q == S_WB)
                    || ((state_q == S_EXEC) && (cls_q == IC_BRANCH))
                    || ((state_q == S_MEM) && (cls_q == IC_STORE) && dmem_ack);
  assign halted     = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign state      = state_q;

`ifdef MULTI_CYCLE_CTRL_PERF_EN
  logic [63:0] cycle_q, instret_q;

  // Performance counters. Both wrap naturally at 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_q   <= cycle_q + 64'd1;
      if (pc_we)             instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule
